// File: rtl/gb_fb_arbiter.sv
// Shares the single-port Game Boy framebuffer RAM between scanout reads, which
// always win, and PPU writes, which wait in a small FIFO for free cycles.
module gb_fb_arbiter #(
    parameter int GB_W        = 160,
    parameter int GB_H        = 144,
    parameter int ADDR_W      = 15,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              scan_en,
    input  logic [7:0]        scan_x,
    input  logic [7:0]        scan_y,
    output logic [1:0]        scan_pixel,
    output logic              scan_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_x,
    input  logic [7:0]        wr_y,
    input  logic [1:0]        wr_data,
    output logic [7:0]        wr_drop_cnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [1:0]        mem_wdata,
    input  logic [1:0]        mem_rdata
);
    localparam int PTR_W = $clog2(WFIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(WFIFO_DEPTH);
    localparam logic [7:0]       W_LIM = 8'(GB_W);
    localparam logic [7:0]       H_LIM = 8'(GB_H);

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_READ,
        SLOT_WRITE
    } slot_t;

    // y*160 + x without a multiplier; shared by both clients.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [7:0] y);
        logic [16:0] sum;
        sum = ({9'd0, y} << 7) + ({9'd0, y} << 5) + {9'd0, x};
        return sum[ADDR_W-1:0];
    endfunction

    logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
    logic [1:0]        fifo_data [WFIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              tag_valid;
    logic [ADDR_W-1:0] tag_addr;
    logic              rd_pend1;
    logic              rd_pend2;
    logic              en_d1;
    logic              en_d2;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_in_range;
    logic              accept;
    logic              push;
    logic              pop;
    slot_t             slot;

    assign scan_addr   = pix_addr(scan_x, scan_y);
    assign wr_addr     = pix_addr(wr_x, wr_y);
    assign wr_in_range = (wr_x < W_LIM) && (wr_y < H_LIM);
    assign wr_ready    = (count != FULL);
    assign accept      = wr_valid && wr_ready;
    assign push        = accept && wr_in_range;
    assign pop         = (slot == SLOT_WRITE);

    always_comb begin
        slot = SLOT_IDLE;
        if (scan_en && (!tag_valid || (scan_addr != tag_addr)))
            slot = SLOT_READ;
        else if (count != '0)
            slot = SLOT_WRITE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_addr[wr_ptr] <= wr_addr;
                fifo_data[wr_ptr] <= wr_data;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= 2'b00;
        end else begin
            mem_we <= 1'b0;
            case (slot)
                SLOT_READ: mem_addr <= scan_addr;
                SLOT_WRITE: begin
                    mem_addr  <= fifo_addr[rd_ptr];
                    mem_wdata <= fifo_data[rd_ptr];
                    mem_we    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A new frame or a blanked line forces the next scanned pixel to be re-read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_valid <= 1'b0;
            tag_addr  <= '0;
        end else if (slot == SLOT_READ) begin
            tag_valid <= 1'b1;
            tag_addr  <= scan_addr;
        end else if (frame_start || !scan_en) begin
            tag_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_pend1    <= 1'b0;
            rd_pend2    <= 1'b0;
            en_d1       <= 1'b0;
            en_d2       <= 1'b0;
            scan_valid  <= 1'b0;
            scan_pixel  <= 2'b00;
            wr_drop_cnt <= 8'd0;
        end else begin
            rd_pend1   <= (slot == SLOT_READ);
            rd_pend2   <= rd_pend1;
            en_d1      <= scan_en;
            en_d2      <= en_d1;
            scan_valid <= en_d2;
            if (rd_pend2)
                scan_pixel <= mem_rdata;
            if (accept && !wr_in_range && (wr_drop_cnt != 8'hFF))
                wr_drop_cnt <= wr_drop_cnt + 8'd1;
        end
    end

endmodule

// File: doc/gb_fb_arbiter.md
Name: gb_fb_arbiter

Overview:
- Shares one single-port Game Boy framebuffer RAM (160x144 pixels, 2 bits each) between two clients: the PPU pixel writer and the DVI scanout reader.
- The scanout reader is driven by the gb_en / gb_x / gb_y outputs of the DVI timing generator.
- Scanout reads have strict priority. PPU writes are buffered in a small FIFO and drained in the free cycles between scanout reads.
- The block sits between the timing generator, the PPU and the framebuffer RAM.

Parameters:
- GB_W, 160, framebuffer width in pixels.
- GB_H, 144, framebuffer height in pixels.
- ADDR_W, 15, RAM address width (GB_W*GB_H = 23040 < 2^15).
- WFIFO_DEPTH, 4, write FIFO entries (power of 2, minimum 2).

Ports:
- clk  in  1  system (pixel) clock
- rst  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of each DVI frame (from vs edge)
- scan_en  in  1  scanout window active (gb_en)
- scan_x  in  8  scanout GB column
- scan_y  in  8  scanout GB row
- scan_pixel  out  2  pixel read for scanout
- scan_valid  out  1  scan_pixel corresponds to the current 3-cycle-delayed scan_en
- wr_valid  in  1  PPU write request
- wr_ready  out  1  FIFO can accept (= not full)
- wr_x  in  8  write column
- wr_y  in  8  write row
- wr_data  in  2  write pixel
- wr_drop_cnt  out  8  saturating count of out-of-range writes
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  2  RAM write data (registered)
- mem_rdata  in  2  RAM read data, valid 1 cycle after the address

Behaviour:
- Reset (rst==0 at posedge): FIFO empty, so wr_ready=1 after reset.
  - Zero on reset: mem_addr, mem_we, mem_wdata, scan_pixel, scan_valid, wr_drop_cnt.
  - Read tag cleared to invalid.
  - Reset mid-operation discards FIFO contents and any in-flight read.
- Address formation: addr = y*160 + x, computed as (y<<7)+(y<<5)+x, truncated to ADDR_W bits. The same formula is used for both clients.
- Write acceptance:
  - A write is accepted when wr_valid && wr_ready at posedge.
  - If wr_x>=GB_W or wr_y>=GB_H, the write is accepted but dropped (not pushed), and wr_drop_cnt increments, saturating at 255.
  - Otherwise the computed address and data are pushed.
  - wr_ready depends only on the registered FIFO count, never combinationally on wr_valid.
- Arbitration, evaluated every cycle N:
  - READ when scan_en==1 and (read tag invalid or scan address != tag). Register mem_addr=scan address, mem_we=0, and update the tag.
  - Else WRITE when the FIFO is non-empty. Pop the head and register mem_addr/mem_wdata, mem_we=1.
  - Else IDLE: mem_we=0, mem_addr held.
- A READ always wins over a pending write. Because scanout advances one GB pixel per 3 clocks, at least 2 write slots occur per GB pixel.
- Push and pop in the same cycle are allowed at any occupancy except push when full, which cannot occur because wr_ready=0.
- Read pipeline:
  - Decision at cycle N drives the mem ports in cycle N+1; mem_rdata is valid in N+2.
  - scan_pixel is registered at the end of N+2 and visible from N+3.
  - scan_pixel holds its value between reads.
  - scan_valid = scan_en delayed by exactly 3 cycles.
- Tag invalidation: frame_start==1 or scan_en==0 invalidates the tag. The first pixel of every line and frame is therefore re-read, even if it has the same address as the last read.
- Read/write hazard: a write to the address being scanned lands after any read already issued. Whether the new data is displayed depends only on the next read of that address; there is no bypass.
- frame_start and a READ decision in the same cycle: the READ is issued and the tag is set to the new address.

Test Plan:
- Reset: hold rst=0 for 4 clocks with wr_valid=1 -> wr_ready=1, mem_we=0, scan_valid=0, wr_drop_cnt=0; no push occurs while in reset.
- Read latency: preload RAM addr 161 (x=1, y=1) with 2'b11, set scan_en=1, scan_x=1, scan_y=1 at cycle 0 -> mem_addr=161 at cycle 1; scan_pixel=2'b11 and scan_valid=1 at cycle 3; no second read while coordinates are held.
- Arbitration: scanout steps x every 3 cycles while the PPU streams 8 writes back-to-back -> every x change issues a read next cycle; all 8 writes reach RAM in order; wr_ready deasserts when 4 are pending and recovers.
- Out-of-range: write x=160, y=0 and then x=0, y=144 -> no mem_we, wr_drop_cnt=2; 300 such writes -> wr_drop_cnt=255.
- Boundary address: write x=159, y=143 with data 2'b01 -> mem_addr=23039, mem_wdata=01, mem_we=1 for exactly one cycle.
- Tag invalidation: hold scan_x=5, scan_y=5, pulse frame_start -> a second read of addr 805 is issued; drop and raise scan_en at the same coordinate -> a read is reissued.
